uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmit path; the counterpart of the receive-side filter and deserializer.
- Accepts parallel words over a valid/ready handshake and stores them in a one-entry holding register.
- Serializes each word onto TXD as start, data (LSB first), optional parity and stop bits, with every bit boundary aligned to the TXC bit-rate strobe.
- Sits between the host/transmit FIFO and the TXD output pad.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop-bit periods (1 or 2).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- TXC  input  1  bit-rate strobe; high for exactly one CLK cycle per bit period, synchronous to CLK.
- TX_DATA  input  DATA_WIDTH  word to transmit.
- TX_VALID  input  1  TX_DATA is valid.
- TX_READY  output  1  holding register empty; a word is accepted when TX_VALID & TX_READY.
- TXD  output  1  serial line, registered, idles high.
- BUSY  output  1  high while a frame is in progress or a word is held.

Behaviour:
- Reset (async assert, sync release): TXD=1, TX_READY=1, BUSY=0, holding register empty, state IDLE, counters 0.
- TX_READY = ~hold_full (combinational from a flop). A word is accepted on a CLK edge with TX_VALID & TX_READY; hold_full=1 on the next cycle.
- Accept (needs hold empty) and load (needs hold full) are mutually exclusive. A word accepted in the same cycle as a TXC strobe is not loaded until the next TXC strobe.
- State machine; all transitions occur only on CLK edges where TXC=1:
  - IDLE: if hold_full, move hold into the shift register, clear hold_full, TXD<=0, go to START. Otherwise TXD stays 1.
  - START: TXD<=data[0], bit_cnt<=1, go to DATA.
  - DATA: if bit_cnt<DATA_WIDTH, TXD<=next bit (LSB first) and bit_cnt++. Otherwise go to PARITY if PARITY_EN, else TXD<=1 and go to STOP.
  - PARITY: on entry TXD<= XOR(data) ^ PARITY_ODD. On the next strobe TXD<=1 and go to STOP.
  - STOP: stop_cnt counts strobes; after STOP_BITS periods, either:
    - if hold_full: load it, TXD<=0, go to START (back-to-back, no idle gap);
    - else go to IDLE with TXD=1.
- Each bit therefore lasts exactly one TXC period. A frame is 1+DATA_WIDTH+PARITY_EN+STOP_BITS periods, e.g. 10 for 8N1.
- Latency: TXD falls on the first TXC strobe after acceptance, not combinationally.
- TX_DATA is captured at acceptance; later changes to TX_DATA do not affect the frame.
- BUSY = (state!=IDLE) | hold_full.
- TXC high for more than one cycle is illegal; each high cycle counts as a strobe, with no protection.
- Reset asserted mid-frame: TXD goes to 1 immediately (async), the held word is discarded, the frame is aborted, and there is no partial resume after release.
- TX_VALID held high with TX_READY low: no acceptance; the source must hold TX_DATA stable.

Test Plan:
- Reset, then TXC every 4 CLK, 8N1, send 0xA5 -> TXD per period = 0,1,0,1,0,0,1,0,1,1, then stays 1; BUSY drops after the stop bit; TX_READY is 0 for exactly one cycle after acceptance.
- PARITY_EN=1: send 0xA5 with PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame is 11 periods.
- Back-to-back: offer 0x00 then 0xFF while TX_VALID is held high -> second word accepted the cycle after the first loads. TXD = 0, eight 0s, 1, then 0, eight 1s, 1, with no extra idle period; TX_READY stays low while the second word is held.
- STOP_BITS=2, send 0x3C -> stop level 1 lasts 2 TXC periods before the next start bit or idle.
- Assert RST_N low during data bit 3 of 0x55 with a second word held -> TXD=1 the same cycle, TX_READY=1, BUSY=0. After release, TXD stays high until a new word is sent and the discarded word never appears.
- Strobe alignment: accept a word on the same cycle as a TXC strobe -> TXD stays high until the following strobe. Changing TX_DATA after acceptance does not alter the transmitted bits.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one-entry holding register feeding a TXC-paced UART frame serializer.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  TXC,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  TXD,
    output logic                  BUSY
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] hold, shreg;
    logic [CW-1:0] bit_cnt;
    logic hold_full, par, stop_cnt, data_done, stop_done, load;

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        data_done = bit_cnt == CW'(DATA_WIDTH);
        stop_done = (STOP_BITS < 2) || stop_cnt;
        load = TXC && hold_full && (state == IDLE || (state == STOP && stop_done));
        state_nx = state;
        if (TXC)
            case (state)
                IDLE:    state_nx = hold_full ? START : IDLE;
                START:   state_nx = DATA;
                DATA:    state_nx = !data_done ? DATA : PARITY_EN ? PARITY : STOP;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = !stop_done ? STOP : hold_full ? START : IDLE;
                default: state_nx = IDLE;
            endcase
    end

    always_comb begin
        TX_READY = ~hold_full;
        BUSY = state != IDLE || hold_full;
    end

    // Parity is latched at load so the shift register can be consumed bit by bit.
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            hold      <= '0;
            shreg     <= '0;
            hold_full <= 1'b0;
            par       <= 1'b0;
            stop_cnt  <= 1'b0;
            bit_cnt   <= '0;
            TXD       <= 1'b1;
        end else begin
            if (TX_VALID && !hold_full) begin
                hold      <= TX_DATA;
                hold_full <= 1'b1;
            end else if (load)
                hold_full <= 1'b0;
            if (TXC && state == STOP)
                stop_cnt <= !stop_done;
            if (load) begin
                shreg <= hold;
                par   <= (^hold) ^ PARITY_ODD;
                TXD   <= 1'b0;
            end else if (TXC)
                case (state)
                    START: begin
                        TXD     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= CW'(1);
                    end
                    DATA:
                        if (!data_done) begin
                            TXD     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + CW'(1);
                        end else
                            TXD <= PARITY_EN ? par : 1'b1;
                    default: TXD <= 1'b1;
                endcase
        end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: checks three frame formats (8N1, 8E1, 8O2) against a bit-queue frame model.
module tb_uart_tx_serializer;
    logic CLK = 1'b0, RST_N = 1'b0, TXC = 1'b0;
    logic vld [3];
    logic txd [3], rdy [3], bsy [3];
    logic [7:0] dat [3];
    int tests = 0, fails = 0, phase = 0;
    int pe [3] = '{0, 1, 1};
    int po [3] = '{0, 0, 1};
    int sb [3] = '{1, 1, 2};
    bit exp_q [$];

    always #5 CLK = ~CLK;

    uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) d0 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TX_DATA(dat[0]), .TX_VALID(vld[0]),
        .TX_READY(rdy[0]), .TXD(txd[0]), .BUSY(bsy[0]));
    uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) d1 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TX_DATA(dat[1]), .TX_VALID(vld[1]),
        .TX_READY(rdy[1]), .TXD(txd[1]), .BUSY(bsy[1]));
    uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) d2 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TX_DATA(dat[2]), .TX_VALID(vld[2]),
        .TX_READY(rdy[2]), .TXD(txd[2]), .BUSY(bsy[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected line levels for one frame, one entry per bit period.
    task automatic frame(input int i, input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
        if (pe[i] != 0) exp_q.push_back((^d) ^ (po[i] != 0));
        repeat (sb[i]) exp_q.push_back(1'b1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        phase = (phase + 1) % 4;
        TXC = (phase == 0);
    endtask

    task automatic strobe();
        bit was;
        do begin
            was = TXC;
            step();
        end while (!was);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        dat[i] = d;
        vld[i] = 1'b1;
        step();
        vld[i] = 1'b0;
        chk($sformatf("d%0d_accept_rdy", i), rdy[i], 1'b0);
        chk($sformatf("d%0d_accept_busy", i), bsy[i], 1'b1);
    endtask

    task automatic xmit(input int i);
        while (exp_q.size() > 0) begin
            strobe();
            chk($sformatf("d%0d_bit%0d", i, exp_q.size()), txd[i], exp_q.pop_front());
        end
        chk($sformatf("d%0d_busy_in_stop", i), bsy[i], 1'b1);
        strobe();
        chk($sformatf("d%0d_idle_txd", i), txd[i], 1'b1);
        chk($sformatf("d%0d_idle_busy", i), bsy[i], 1'b0);
        chk($sformatf("d%0d_idle_rdy", i), rdy[i], 1'b1);
    endtask

    task automatic b2b(input int i, input logic [7:0] a, input logic [7:0] b);
        int len_a;
        len_a = 1 + 8 + pe[i] + sb[i];
        while (phase != 3) step();
        frame(i, a);
        frame(i, b);
        dat[i] = a;
        vld[i] = 1'b1;
        step();
        dat[i] = b;
        chk($sformatf("d%0d_b2b_rdy_first", i), rdy[i], 1'b0);
        step();
        chk($sformatf("d%0d_b2b_rdy_loaded", i), rdy[i], 1'b1);
        chk($sformatf("d%0d_b2b_start", i), txd[i], exp_q.pop_front());
        step();
        vld[i] = 1'b0;
        chk($sformatf("d%0d_b2b_rdy_second", i), rdy[i], 1'b0);
        for (int k = 1; k < len_a; k++) begin
            strobe();
            chk($sformatf("d%0d_b2b_bit%0d", i, k), txd[i], exp_q.pop_front());
            chk($sformatf("d%0d_b2b_rdy_held%0d", i, k), rdy[i], 1'b0);
        end
        xmit(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d, r;
        bit aligned;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_txd", i), txd[i], 1'b1);
            chk($sformatf("d%0d_rst_rdy", i), rdy[i], 1'b1);
            chk($sformatf("d%0d_rst_busy", i), bsy[i], 1'b0);
        end
        RST_N = 1'b1;
        step();

        // 8N1 0xA5, accepted just before a strobe: ready low for one cycle only.
        while (phase != 3) step();
        frame(0, 8'hA5);
        send(0, 8'hA5);
        chk("d0_a5_txd_before_strobe", txd[0], 1'b1);
        strobe();
        chk("d0_a5_rdy_one_cycle", rdy[0], 1'b1);
        chk("d0_a5_start", txd[0], exp_q.pop_front());
        xmit(0);

        for (int i = 1; i < 3; i++) begin
            frame(i, 8'hA5);
            send(i, 8'hA5);
            xmit(i);
        end

        b2b(0, 8'h00, 8'hFF);
        b2b(2, 8'h3C, 8'hA5);

        // Reset during data bit 3 of 0x55 with 0x0F held.
        while (phase != 3) step();
        send(0, 8'h55);
        strobe();
        send(0, 8'h0F);
        repeat (4) strobe();
        r = 8'h55;
        chk("d0_rst_bit3", txd[0], r[3]);
        step();
        RST_N = 1'b0;
        #1;
        chk("d0_midrst_txd", txd[0], 1'b1);
        chk("d0_midrst_rdy", rdy[0], 1'b1);
        chk("d0_midrst_busy", bsy[0], 1'b0);
        step();
        RST_N = 1'b1;
        for (int k = 0; k < 24; k++) begin
            strobe();
            chk($sformatf("d0_postrst_txd%0d", k), txd[0], 1'b1);
        end
        chk("d0_postrst_busy", bsy[0], 1'b0);
        frame(0, 8'hC3);
        send(0, 8'hC3);
        xmit(0);

        // Random words, random alignment; TX_DATA scrambled after acceptance.
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 6; n++) begin
                d = 8'($urandom);
                repeat ($urandom_range(0, 5)) step();
                aligned = (n < 2);
                if (aligned) while (!TXC) step();
                frame(i, d);
                send(i, d);
                dat[i] = 8'($urandom);
                if (aligned) begin
                    chk($sformatf("d%0d_align_txd_hi", i), txd[i], 1'b1);
                    repeat (3) step();
                    chk($sformatf("d%0d_align_txd_wait", i), txd[i], 1'b1);
                end
                xmit(i);
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
